// File: rtl/mini_sldu_ctrl.sv
// Broadcast sequencer for the per-lane mini SLDU chain: walks source lanes
// round-robin, loads one operand at a time and broadcasts it to every VMFPU.
module mini_sldu_ctrl #(
  parameter int NrLanes  = 4,
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [CntWidth-1:0] cmd_len_i,
  input  logic                abort_i,
  input  logic [NrLanes-1:0]  src_valid_i,
  output logic [NrLanes-1:0]  src_pop_o,
  output logic [NrLanes-1:0]  bc_load_o,
  output logic                bc_valid_o,
  input  logic [NrLanes-1:0]  bc_ready_i,
  output logic                bc_consume_o,
  output logic                bc_invalidate_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int IdxW = $clog2(NrLanes);

  typedef enum logic [1:0] {IDLE, LOAD, BCAST, FLUSH} state_t;

  state_t              state_reg, state_next;
  logic [CntWidth-1:0] remaining_reg, remaining_next;
  logic [IdxW-1:0]     src_idx_reg, src_idx_next;

  logic [IdxW-1:0]     src_idx_inc;
  logic                fire;
  logic                last_elem;
  logic                load_cur;
  logic                load_nxt;
  logic                pop_en;
  logic [IdxW-1:0]     pop_idx;
  logic [NrLanes-1:0]  sel_onehot;

  // NrLanes is a power of two, so the increment wraps to lane 0 for free.
  assign src_idx_inc = src_idx_reg + IdxW'(1);
  assign fire        = (state_reg == BCAST) && (&bc_ready_i) && !abort_i;
  assign last_elem   = (remaining_reg == CntWidth'(1));
  assign load_cur    = (state_reg == LOAD) && src_valid_i[src_idx_reg] && !abort_i;
  assign load_nxt    = fire && !last_elem && src_valid_i[src_idx_inc];
  assign pop_en      = load_cur || load_nxt;
  assign pop_idx     = load_nxt ? src_idx_inc : src_idx_reg;

  generate
    for (genvar gi = 0; gi < NrLanes; gi++) begin : g_sel
      assign sel_onehot[gi] = pop_en && (pop_idx == IdxW'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      src_idx_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      src_idx_reg   <= src_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    src_idx_next   = src_idx_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_len_i == '0) begin
            state_next = FLUSH;
          end else begin
            state_next     = LOAD;
            remaining_next = cmd_len_i;
            src_idx_next   = '0;
          end
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_next = FLUSH;
        end else if (src_valid_i[src_idx_reg]) begin
          state_next = BCAST;
        end
      end
      BCAST: begin
        if (abort_i) begin
          state_next = FLUSH;
        end else if (fire) begin
          remaining_next = remaining_reg - CntWidth'(1);
          src_idx_next   = src_idx_inc;
          if (last_elem) begin
            state_next = FLUSH;
          end else if (src_valid_i[src_idx_inc]) begin
            state_next = BCAST;
          end else begin
            state_next = LOAD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Every output is forced low while reset is held, including cmd_ready_o.
  always_comb begin
    cmd_ready_o     = 1'b0;
    busy_o          = 1'b0;
    bc_valid_o      = 1'b0;
    bc_consume_o    = 1'b0;
    bc_invalidate_o = 1'b0;
    done_o          = 1'b0;
    src_pop_o       = '0;
    bc_load_o       = '0;
    if (rst_ni) begin
      cmd_ready_o     = (state_reg == IDLE);
      busy_o          = (state_reg != IDLE);
      bc_valid_o      = (state_reg == BCAST);
      bc_consume_o    = fire;
      bc_invalidate_o = (state_reg == FLUSH);
      done_o          = (state_reg == FLUSH);
      src_pop_o       = sel_onehot;
      bc_load_o       = sel_onehot;
    end
  end

endmodule

// File: tb/tb_mini_sldu_ctrl.sv
// Self-checking bench for mini_sldu_ctrl: element-count reference model checked
// every cycle, directed scenarios with literal timing, then random traffic.
module tb_mini_sldu_ctrl;
  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_len;
  logic         abort;
  logic [N-1:0] src_valid;
  logic [N-1:0] src_pop;
  logic [N-1:0] bc_load;
  logic         bc_valid;
  logic [N-1:0] bc_ready;
  logic         bc_consume;
  logic         bc_invalidate;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  mini_sldu_ctrl #(.NrLanes(N), .CntWidth(W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len),
    .abort_i(abort), .src_valid_i(src_valid), .src_pop_o(src_pop),
    .bc_load_o(bc_load), .bc_valid_o(bc_valid), .bc_ready_i(bc_ready),
    .bc_consume_o(bc_consume), .bc_invalidate_o(bc_invalidate),
    .busy_o(busy), .done_o(done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a command is a count of elements consumed, plus whether
  // one element is currently sitting on the chain waiting for all lanes.
  bit m_active, m_hold, m_flush;
  int m_len, m_cons;

  int cons_total = 0, done_total = 0, inv_total = 0;
  int accept_cyc = -100, done_cyc = -200;
  int pop_lane_q[$];
  int pop_cyc_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    bit           idle, e_valid, e_cons, e_pop;
    int           nxt, lane;
    logic [N-1:0] e_pop_vec;
    @(negedge clk);
    cyc++;
    idle    = !m_active && !m_flush;
    e_valid = rst_n && m_active && m_hold;
    e_cons  = e_valid && (&bc_ready) && !abort;
    nxt     = m_cons + (m_hold ? 1 : 0);
    lane    = nxt % N;
    e_pop   = rst_n && m_active && !abort && (!m_hold || e_cons) &&
              (nxt < m_len) && src_valid[lane];
    e_pop_vec = '0;
    if (e_pop) e_pop_vec[lane] = 1'b1;

    check("cmd_ready", int'(cmd_ready), int'(rst_n && idle));
    check("busy", int'(busy), int'(rst_n && !idle));
    check("bc_valid", int'(bc_valid), int'(e_valid));
    check("bc_consume", int'(bc_consume), int'(e_cons));
    check("src_pop", int'(src_pop), int'(e_pop_vec));
    check("bc_load", int'(bc_load), int'(e_pop_vec));
    check("done", int'(done), int'(rst_n && m_flush));
    check("bc_invalidate", int'(bc_invalidate), int'(rst_n && m_flush));

    if (cmd_ready && cmd_valid) accept_cyc = cyc;
    if (bc_consume) cons_total++;
    if (bc_invalidate) inv_total++;
    if (done) begin
      done_total++;
      done_cyc = cyc;
    end
    for (int i = 0; i < N; i++) begin
      if (src_pop[i]) begin
        pop_lane_q.push_back(i);
        pop_cyc_q.push_back(cyc);
      end
    end

    if (!rst_n) begin
      m_active = 0; m_hold = 0; m_flush = 0; m_len = 0; m_cons = 0;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (!m_active) begin
      if (cmd_valid) begin
        if (cmd_len == '0) begin
          m_flush = 1;
        end else begin
          m_active = 1; m_len = int'(cmd_len); m_cons = 0; m_hold = 0;
        end
      end
    end else if (abort) begin
      m_active = 0; m_hold = 0; m_flush = 1;
    end else begin
      if (e_cons) m_cons++;
      if (e_pop) m_hold = 1;
      else if (e_cons) m_hold = 0;
      if (m_cons == m_len) begin
        m_active = 0; m_hold = 0; m_flush = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input int len);
    cmd_valid = 1'b1;
    cmd_len   = W'(len);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int c0, d0, i0, p0, np;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; abort = 1'b0;
    src_valid = '1; bc_ready = '1;
    m_active = 0; m_hold = 0; m_flush = 0; m_len = 0; m_cons = 0;
    @(posedge clk);
    #1;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("reset_release_ready", int'(cmd_ready), 1);
    check("reset_release_busy", int'(busy), 0);
    tick();

    // len=6, everything ready: lanes 0,1,2,3,0,1 on consecutive cycles
    c0 = cons_total; i0 = inv_total; p0 = pop_lane_q.size();
    start_cmd(6);
    repeat (10) tick();
    np = pop_lane_q.size() - p0;
    check("s1_consumes", cons_total - c0, 6);
    check("s1_done_latency", done_cyc - accept_cyc, 8);
    check("s1_invalidates", inv_total - i0, 1);
    check("s1_pop_count", np, 6);
    for (int k = 0; k < np && k < 6; k++) begin
      check("s1_pop_lane", pop_lane_q[p0+k], k % N);
      check("s1_pop_cycle", pop_cyc_q[p0+k] - accept_cyc, 1 + k);
    end

    // len=3, lane 1 source empty for a while after element 0 goes out
    c0 = cons_total; p0 = pop_lane_q.size();
    start_cmd(3);
    tick();
    src_valid = 4'b1101;
    repeat (5) tick();
    src_valid = '1;
    repeat (8) tick();
    np = pop_lane_q.size() - p0;
    check("s2_consumes", cons_total - c0, 3);
    check("s2_pop_count", np, 3);
    check("s2_done_latency", done_cyc - accept_cyc, 10);
    if (np >= 2) check("s2_lane1_pop_cycle", pop_cyc_q[p0+1] - accept_cyc, 7);

    // len=2, one lane not ready for five cycles
    c0 = cons_total; p0 = pop_lane_q.size();
    start_cmd(2);
    bc_ready = 4'b1011;
    repeat (5) tick();
    bc_ready = '1;
    repeat (6) tick();
    np = pop_lane_q.size() - p0;
    check("s3_consumes", cons_total - c0, 2);
    check("s3_done_latency", done_cyc - accept_cyc, 8);
    if (np >= 2) check("s3_second_pop_cycle", pop_cyc_q[p0+1] - accept_cyc, 6);

    // len=8, abort while the third element is on the chain
    c0 = cons_total; p0 = pop_lane_q.size();
    start_cmd(8);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (4) tick();
    check("s4_consumes", cons_total - c0, 2);
    check("s4_pops", pop_lane_q.size() - p0, 3);
    check("s4_done_latency", done_cyc - accept_cyc, 5);
    check("s4_idle_ready", int'(cmd_ready), 1);

    // len=0
    c0 = cons_total; i0 = inv_total; p0 = pop_lane_q.size();
    start_cmd(0);
    repeat (3) tick();
    check("s5_done_latency", done_cyc - accept_cyc, 1);
    check("s5_pops", pop_lane_q.size() - p0, 0);
    check("s5_consumes", cons_total - c0, 0);
    check("s5_invalidates", inv_total - i0, 1);

    // len=10, reset after four consumes, then a len=1 command
    c0 = cons_total; d0 = done_total;
    start_cmd(10);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("s6_reset_busy", int'(busy), 0);
    check("s6_reset_valid", int'(bc_valid), 0);
    check("s6_reset_ready", int'(cmd_ready), 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("s6_after_reset_ready", int'(cmd_ready), 1);
    tick();
    check("s6_no_done", done_total - d0, 0);
    check("s6_consumes_before_reset", cons_total - c0, 4);
    start_cmd(1);
    repeat (4) tick();
    check("s6_new_done_latency", done_cyc - accept_cyc, 3);
    check("s6_total_consumes", cons_total - c0, 5);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_len   = ($urandom_range(0, 19) == 0) ? W'(16'hFFFF) : W'($urandom_range(0, 9));
      abort     = ($urandom_range(0, 24) == 0);
      src_valid = ($urandom_range(0, 1) == 0) ? '1 : N'($urandom);
      bc_ready  = ($urandom_range(0, 1) == 0) ? '1 : N'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mini_sldu_ctrl.md
# mini_sldu_ctrl

Broadcast sequencer for the per-lane mini SLDU chain used by the matmul datapath. It accepts one broadcast command (element count), walks the source lane round-robin (element i lives in lane i mod NrLanes), pops that lane's operand into its mini SLDU, and presents each element to every lane's VMFPU at once. It sits in the Ara top-level matmul control path, between the sequencer command stream and the NrLanes mini SLDU/VMFPU pairs.

## Interface
- NrLanes, 4: number of lanes in the chain; power of two, ≥2.
- CntWidth, 16: width of the element count.

- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- cmd_valid_i  in  1  broadcast command valid.
- cmd_ready_o  out  1  controller can accept a command.
- cmd_len_i  in  CntWidth  number of elements to broadcast (0 allowed).
- abort_i  in  1  flush the current command.
- src_valid_i  in  NrLanes  lane operand queue holds an element.
- src_pop_o  out  NrLanes  one-hot pop of the selected lane's operand queue.
- bc_load_o  out  NrLanes  one-hot: the selected lane's mini SLDU loads its local operand onto the chain.
- bc_valid_o  out  1  broadcast element valid to all VMFPUs.
- bc_ready_i  in  NrLanes  per-lane VMFPU ready.
- bc_consume_o  out  1  element consumed by all lanes (bc_valid_o & &bc_ready_i).
- bc_invalidate_o  out  1  one-cycle pulse: mini SLDUs drop buffered data.
- busy_o  out  1  state ≠ IDLE.
- done_o  out  1  one-cycle pulse at command end (normal or abort).

## Operation
- States: IDLE, LOAD, BCAST, FLUSH. Registers: state, remaining (CntWidth), src_idx (log2 NrLanes).
- IDLE: cmd_ready_o=1. On cmd_valid_i: len==0 → FLUSH; else remaining=len, src_idx=0 → LOAD. abort_i ignored in IDLE.
- LOAD: if src_valid_i[src_idx]: src_pop_o and bc_load_o = onehot(src_idx) that cycle → BCAST; else stay, outputs 0.
- BCAST: bc_valid_o=1. Fire = &bc_ready_i (bc_consume_o=1). On fire: remaining−1; src_idx wraps NrLanes−1→0.
  - remaining==1 at fire → FLUSH.
  - else if src_valid_i[next src_idx]: pop/load next lane same cycle, stay BCAST (back-to-back).
  - else → LOAD.
  - No fire: hold; no pop/load.
- FLUSH: bc_invalidate_o=1, done_o=1 for exactly one cycle → IDLE.
- abort_i in LOAD/BCAST: next state FLUSH; that cycle src_pop_o, bc_load_o, bc_consume_o forced 0 (element not counted). abort_i in FLUSH: no effect.
- Partial ready: bc_ready_i not all-ones never consumes; bc_valid_o stays high, element held.
- Pops per command == min(len, elements loaded before abort); never pops a lane whose src_valid_i is 0.

## Timing
- All outputs are decoded from state plus current inputs; no output registers.
- Reset: rst_ni low at an edge → state=IDLE, remaining=0, src_idx=0. While rst_ni low, all outputs 0 (cmd_ready_o gated). After release: cmd_ready_o=1, others 0.
- Reset mid-command: discards command, no done_o/invalidate pulse.
- Command accepted at cycle T; earliest load T+1; first bc_valid_o T+2.
- Sources always valid and all ready: one element per cycle, last consume at T+1+len, done_o/bc_invalidate_o at T+2+len, cmd_ready_o at T+3+len.
- len==0: done_o at T+1, cmd_ready_o at T+2.
- Abort asserted in cycle A (non-IDLE, non-FLUSH): done_o at A+1.
- remaining decrements only on fire; a count of 2^CntWidth−1 must complete without wrap.

## Test plan
- NrLanes=4, len=6, all src_valid/bc_ready high → pops lanes 0,1,2,3,0,1 on consecutive cycles T+1..T+6, six bc_consume_o pulses, done_o at T+8, one invalidate.
- len=3, src_valid_i[1] low for 4 cycles after element 0 consumed → state goes LOAD, holds with no pops, resumes when it rises; total 3 consumes, no pop of lane 1 while invalid.
- len=2, bc_ready_i=4'b1011 for 5 cycles then 4'b1111 → bc_valid_o held high, no consume/pop during stall, then 2 consumes and done_o.
- len=8, abort_i pulsed in cycle of 3rd element's BCAST with all ready → exactly 2 consumes counted, no consume/pop in abort cycle, done_o+invalidate next cycle, back in IDLE.
- len=0 → no pops/valid, done_o and bc_invalidate_o one cycle after accept.
- rst_ni low for one cycle mid-command (len=10, after 4 consumes) → all outputs 0 during reset, IDLE afterwards, no done_o; new len=1 command completes normally.
